// File: rtl/rv_pkg.sv
// Shared types and constants for the fetch front end: FSM states, IF/ID register layout,
// and the canonical NOP/EBREAK encodings.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [XLEN-1:0] EBREAK_INSTR = 32'h0010_0073;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } fetch_state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/pc_gen.sv
// Program counter register with next-PC selection (load/advance/hold), word alignment of
// load targets and the instruction-memory range check.
module pc_gen import rv_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     IMEM_WORDS = 1024
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            advance_i,
  input  logic [XLEN-1:0] load_pc_i,
  output logic [XLEN-1:0] pc_o,
  output logic            in_range_o
);

  // One extra bit so IMEM_WORDS*4 == 2^32 still compares correctly.
  localparam logic [XLEN:0]   PcLimit   = (XLEN + 1)'(IMEM_WORDS) << 2;
  localparam logic [XLEN-1:0] AlignMask = ~XLEN'(3);

  logic [XLEN-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_pc_i & AlignMask;
    end else if (advance_i) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o       = pc_q;
  assign in_range_o = {1'b0, pc_q} < PcLimit;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch front end: boot/run/halt FSM and IF/ID register around pc_gen.
// Define FETCH_PERF_CNT_EN to add the perf_fetched/perf_stall counters.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1024,
  parameter logic [31:0] NOP_INSTR  = rv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] icache_raddr,
  output logic        icache_ren,
  input  logic [31:0] icache_dout,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        halted,
  output logic        fetch_fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);
  import rv_pkg::*;

  fetch_state_e state_q;
  if_id_t       if_id_q;
  logic         fault_q;
  logic         pc_load, pc_adv, pc_in_range;
  logic [31:0]  pc;

  pc_gen #(
    .RESET_PC  (RESET_PC),
    .IMEM_WORDS(IMEM_WORDS)
  ) u_pc_gen (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (pc_load),
    .advance_i (pc_adv),
    .load_pc_i (redirect_pc),
    .pc_o      (pc),
    .in_range_o(pc_in_range)
  );

  // PC stays on an EBREAK so a later redirect is the only way forward.
  always_comb begin
    pc_load = 1'b0;
    pc_adv  = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (redirect_valid) begin
          pc_load = 1'b1;
        end else if (!stall && pc_in_range && (icache_dout != EBREAK_INSTR)) begin
          pc_adv = 1'b1;
        end
      end
      S_HALT:  pc_load = redirect_valid;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BOOT;
      if_id_q <= '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
      fault_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_BOOT: state_q <= S_RUN;
        S_RUN: begin
          if (redirect_valid) begin
            if_id_q.valid <= 1'b0;
            if_id_q.instr <= NOP_INSTR;
          end else if (stall) begin
            if_id_q <= if_id_q;
          end else if (!pc_in_range) begin
            if_id_q.valid <= 1'b0;
            fault_q       <= 1'b1;
            state_q       <= S_HALT;
          end else begin
            if_id_q <= '{valid: 1'b1, pc: pc, instr: icache_dout};
            if (icache_dout == EBREAK_INSTR) state_q <= S_HALT;
          end
        end
        S_HALT: begin
          if_id_q.valid <= 1'b0;
          if_id_q.instr <= NOP_INSTR;
          if (redirect_valid) state_q <= S_RUN;
        end
        default: state_q <= S_BOOT;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else if (state_q == S_RUN && !redirect_valid) begin
      if (stall) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end else if (pc_in_range) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

  assign icache_raddr = pc;
  assign icache_ren   = (state_q != S_HALT) && !stall && !rst;
  assign id_valid     = if_id_q.valid;
  assign id_pc        = if_id_q.pc;
  assign id_instr     = if_id_q.instr;
  assign halted       = (state_q == S_HALT);
  assign fetch_fault  = fault_q;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch front end. Owns the program counter and drives the instruction cache read port (address, read enable).
- Captures the returned word into the IF/ID pipeline register consumed by decode.
- Handles stall (hold), redirect (branch/jump flush), and halt on EBREAK.
- Sits between the hazard/branch unit and the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 1024, instruction memory depth in 32-bit words; PCs at or above IMEM_WORDS*4 are out of range.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID on flush or halt.

Ports:
- clk  input  1  system clock; rising edge for all state in this block.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hazard unit hold request; freezes PC and IF/ID.
- redirect_valid  input  1  branch/jump taken; load redirect_pc and flush.
- redirect_pc  input  32  redirect target.
- icache_raddr  output  32  byte address to icache, equal to pc.
- icache_ren  output  1  icache read enable.
- icache_dout  input  32  word from icache. Sampled on the falling edge inside the cache, so it is valid before the next rising edge.
- id_valid  output  1  IF/ID register holds a real instruction.
- id_pc  output  32  PC of id_instr.
- id_instr  output  32  fetched instruction.
- halted  output  1  fetch stopped (EBREAK seen or fault).
- fetch_fault  output  1  sticky; PC was out of range.

Behaviour:
- Reset values (asynchronous, immediate):
  - pc=RESET_PC, state=S_BOOT
  - id_valid=0, id_pc=0, id_instr=NOP_INSTR
  - halted=0, fetch_fault=0
- icache_raddr = pc (combinational, stable from rising edge through the cache's falling-edge sample).
- icache_ren = (state!=S_HALT) && !stall && !rst.
- State S_BOOT: lasts exactly one cycle after reset deassertion.
  - ren=1, pc held, id_valid stays 0.
  - Next state S_RUN.
  - This primes icache_dout with mem[RESET_PC>>2].
- State S_RUN: priority at each rising edge is redirect > stall > advance.
  - Redirect: pc<=redirect_pc with bits[1:0] forced to 0; id_valid<=0; id_instr<=NOP_INSTR. One bubble per taken branch. Redirect during stall still wins.
  - Stall (no redirect): pc, id_valid, id_pc, id_instr all hold.
  - Advance: id_pc<=pc; id_instr<=icache_dout; id_valid<=1; pc<=pc+4. Wraps modulo 2^32 (0xFFFF_FFFC -> 0x0).
  - If pc >= IMEM_WORDS*4 when advancing: do not latch dout; id_valid<=0; fetch_fault<=1; go to S_HALT.
  - If the latched word equals 32'h0010_0073 (EBREAK): it is delivered with id_valid=1; pc does not advance; next state S_HALT.
- State S_HALT: halted=1; ren=0.
  - Next edge: id_valid<=0, id_instr<=NOP_INSTR; pc holds.
  - Only redirect_valid exits: pc<=redirect_pc, halted<=0, next S_RUN, fetch_fault unchanged.
  - stall is ignored in S_HALT.
- fetch_fault clears only on reset.
- Reset asserted mid-operation: all state returns to reset values at once. The in-flight icache read is discarded. Boot restarts via S_BOOT.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched[31:0] and perf_stall[31:0], both reset to 0 and wrapping.
  - perf_fetched increments on each advance that sets id_valid=1.
  - perf_stall increments each S_RUN cycle with stall=1 and redirect_valid=0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package rv_pkg:
  - fetch_state_e enum {S_BOOT, S_RUN, S_HALT}
  - constants NOP_INSTR, EBREAK_INSTR=32'h0010_0073, XLEN=32
  - packed struct if_id_t {valid, pc, instr}, used for the IF/ID register.
- One natural sub-module: pc_gen, holding the PC register, next-PC mux, alignment and range check. instr_fetch holds the FSM and IF/ID register.

Test Plan:
- Sequential fetch: preload mem[0..2]=06400313, 01400393, 00730E33; release reset.
  - Cycle 1: id_valid=0 (boot).
  - Cycles 2-4: id_pc=0,4,8 with id_instr=06400313, 01400393, 00730E33; icache_raddr steps 0,4,8,C.
- Stall: assert stall 3 cycles while id_pc=4 -> id_pc/id_instr hold 4/01400393 and icache_ren=0. Resume -> id_pc=8 next.
- Redirect: redirect_valid with redirect_pc=0x0000_0002 at id_pc=4.
  - Next cycle: id_valid=0, id_instr=00000013, pc=0x0.
  - Following cycle: id_pc=0, id_instr=06400313.
  - Repeat with stall=1 as well -> same result.
- EBREAK halt: mem[3]=00100073.
  - id_instr=00100073 with id_valid=1, then halted=1, id_valid=0, icache_ren=0 indefinitely.
  - redirect to 0x0 -> resumes with 06400313.
- Fault: redirect_pc=0x1000 (IMEM_WORDS=1024) -> fetch_fault=1, halted=1, id_valid stays 0. fetch_fault survives a redirect to 0x0; cleared only by rst.
- Async reset: assert rst between clock edges mid-run -> outputs reach reset values before the next edge. With FETCH_PERF_CNT_EN, perf_fetched=0 and perf_stall=0.
